// File: rtl/rs424_serial_tx.sv
// RS-424 framed serial transmitter: start / LSB-first data / optional parity / stop bits,
// each bit held CLKS_PER_BIT clocks and driven as a complementary level pair on tda/tdb.
module rs424_serial_tx #(
   parameter int DATA_W       = 8,
   parameter int LEVEL_W      = 3,
   parameter int LEVEL_HI     = 6,
   parameter int LEVEL_LO     = 1,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [LEVEL_W-1:0] tda,
   output logic [LEVEL_W-1:0] tdb,
   output logic               busy,
   output logic               frame_done
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0]      BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0]      DATA_LAST = IW'(DATA_W - 1);
   localparam logic [IW-1:0]      STOP_LAST = IW'(STOP_BITS - 1);
   localparam logic [LEVEL_W-1:0] LVL_HI    = LEVEL_W'(LEVEL_HI);
   localparam logic [LEVEL_W-1:0] LVL_LO    = LEVEL_W'(LEVEL_LO);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       baud_q, baud_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                par_q, par_d;
   logic [LEVEL_W-1:0]  tda_q, tdb_q;
   logic                busy_q, done_q;
   logic                done_d, bit_d, wrap;

   assign in_ready   = (state_q == S_IDLE) && !rst;
   assign tda        = tda_q;
   assign tdb        = tdb_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      done_d  = 1'b0;
      bit_d   = 1'b1;
      wrap    = (baud_q == BAUD_LAST);
      if (state_q != S_IDLE) baud_d = wrap ? '0 : baud_q + 1'b1;
      case (state_q)
         S_IDLE: if (in_valid) begin
            state_d = S_START;
            shift_d = in_data;
            par_d   = (^in_data) ^ (PARITY_ODD != 0);
            baud_d  = '0;
            idx_d   = '0;
         end
         S_START: if (wrap) state_d = S_DATA;
         S_DATA: if (wrap) begin
            if (idx_q == DATA_LAST) begin
               idx_d   = '0;
               state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
               idx_d   = idx_q + 1'b1;
               shift_d = shift_q >> 1;
            end
         end
         S_PARITY: if (wrap) state_d = S_STOP;
         S_STOP: if (wrap) begin
            if (idx_q == STOP_LAST) begin
               idx_d   = '0;
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Line bit follows the next state so the registered levels line up with it.
      case (state_d)
         S_START:  bit_d = 1'b0;
         S_DATA:   bit_d = shift_d[0];
         S_PARITY: bit_d = par_d;
         default:  bit_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tda_q   <= LVL_LO;
         tdb_q   <= LVL_HI;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tda_q   <= bit_d ? LVL_LO : LVL_HI;
         tdb_q   <= bit_d ? LVL_HI : LVL_LO;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_rs424_serial_tx.sv
// Bench for rs424_serial_tx: four parameter variants driven by directed and random words,
// each line cycle compared against a frame built from the framing rules.
module tb_rs424_serial_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic [3:0] vld;
   logic [3:0] rdy, bsy, fd;
   logic [2:0] a0, b0, a1, b1, a2, b2;
   logic [3:0] a3, b3;
   logic [7:0] la [4];
   logic [7:0] lb [4];

   int cf_dw   [4] = '{8, 8, 8, 5};
   int cf_cpb  [4] = '{4, 4, 4, 1};
   int cf_pen  [4] = '{0, 1, 1, 0};
   int cf_podd [4] = '{0, 0, 1, 0};
   int cf_sb   [4] = '{1, 1, 1, 2};
   int cf_hi   [4] = '{6, 6, 6, 12};
   int cf_lo   [4] = '{1, 1, 1, 3};

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rs424_serial_tx u0 (.clk(clk), .rst(rst), .in_data(din), .in_valid(vld[0]), .in_ready(rdy[0]),
      .tda(a0), .tdb(b0), .busy(bsy[0]), .frame_done(fd[0]));
   rs424_serial_tx #(.PARITY_EN(1)) u1 (.clk(clk), .rst(rst), .in_data(din), .in_valid(vld[1]),
      .in_ready(rdy[1]), .tda(a1), .tdb(b1), .busy(bsy[1]), .frame_done(fd[1]));
   rs424_serial_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .in_data(din),
      .in_valid(vld[2]), .in_ready(rdy[2]), .tda(a2), .tdb(b2), .busy(bsy[2]), .frame_done(fd[2]));
   rs424_serial_tx #(.DATA_W(5), .CLKS_PER_BIT(1), .STOP_BITS(2), .LEVEL_W(4), .LEVEL_HI(12),
      .LEVEL_LO(3)) u3 (.clk(clk), .rst(rst), .in_data(din[4:0]), .in_valid(vld[3]),
      .in_ready(rdy[3]), .tda(a3), .tdb(b3), .busy(bsy[3]), .frame_done(fd[3]));

   always_comb begin
      la[0] = 8'(a0); lb[0] = 8'(b0);
      la[1] = 8'(a1); lb[1] = 8'(b1);
      la[2] = 8'(a2); lb[2] = 8'(b2);
      la[3] = 8'(a3); lb[3] = 8'(b3);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Line level check for a logical bit value b (0 = space, 1 = mark).
   task automatic chk_line(input int i, input bit b, input string tag);
      chk({tag, ".tda"}, 32'(la[i]), b ? 32'(cf_lo[i]) : 32'(cf_hi[i]));
      chk({tag, ".tdb"}, 32'(lb[i]), b ? 32'(cf_hi[i]) : 32'(cf_lo[i]));
   endtask

   task automatic chk_ctl(input int i, input bit b, input bit r, input bit d, input string tag);
      chk({tag, ".busy"}, 32'(bsy[i]), 32'(b));
      chk({tag, ".ready"}, 32'(rdy[i]), 32'(r));
      chk({tag, ".done"}, 32'(fd[i]), 32'(d));
   endtask

   // Sends word w on instance i (unless already accepted) and checks every cycle up to the
   // frame_done cycle. chain holds in_valid with nw so it is accepted right after; noise
   // pulses in_valid with nz mid-frame, which must be ignored.
   task automatic run_frame(input int i, input logic [7:0] w, input bit accepted,
                            input bit chain, input logic [7:0] nw, input bit noise,
                            input logic [7:0] nz);
      bit fb [64];
      int nb, f;
      bit p;
      p = 1'b0;
      fb[0] = 1'b0;
      for (int j = 0; j < cf_dw[i]; j++) begin
         fb[1+j] = w[j];
         p ^= w[j];
      end
      nb = 1 + cf_dw[i];
      if (cf_pen[i] != 0) begin
         fb[nb] = p ^ (cf_podd[i] != 0);
         nb++;
      end
      for (int j = 0; j < cf_sb[i]; j++) fb[nb+j] = 1'b1;
      nb += cf_sb[i];
      f = nb * cf_cpb[i];
      if (!accepted) begin
         chk($sformatf("u%0d.ready_pre", i), 32'(rdy[i]), 32'd1);
         din = w;
         vld[i] = 1'b1;
         @(negedge clk);
      end
      for (int k = 0; k <= f; k++) begin
         if (k < f) begin
            chk_line(i, fb[k / cf_cpb[i]], $sformatf("u%0d.w%02h.c%0d", i, w, k));
            chk_ctl(i, 1'b1, 1'b0, 1'b0, $sformatf("u%0d.w%02h.c%0d", i, w, k));
            if (chain) begin
               vld[i] = 1'b1; din = nw;
            end else if (noise) begin
               vld[i] = 1'($urandom_range(0, 1)); din = nz;
            end else begin
               vld[i] = 1'b0;
            end
         end else begin
            chk_line(i, 1'b1, $sformatf("u%0d.w%02h.end", i, w));
            chk_ctl(i, 1'b0, 1'b1, 1'b1, $sformatf("u%0d.w%02h.end", i, w));
            vld[i] = chain;
            din = nw;
         end
         @(negedge clk);
      end
      vld[i] = 1'b0;
      if (!chain) begin
         chk_line(i, 1'b1, $sformatf("u%0d.w%02h.post", i, w));
         chk_ctl(i, 1'b0, 1'b1, 1'b0, $sformatf("u%0d.w%02h.post", i, w));
      end
   endtask

   initial begin
      rst = 1'b1;
      vld = '0;
      din = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk_line(i, 1'b1, $sformatf("rst.u%0d", i));
         chk_ctl(i, 1'b0, 1'b0, 1'b0, $sformatf("rst.u%0d", i));
      end
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("rel.u%0d.ready", i), 32'(rdy[i]), 32'd1);

      // Directed cases
      run_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      run_frame(1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      run_frame(1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      run_frame(2, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      run_frame(2, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      run_frame(0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
      run_frame(0, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      repeat (3) begin
         @(negedge clk);
         chk_line(0, 1'b1, "b2b.idle");
         chk_ctl(0, 1'b0, 1'b1, 1'b0, "b2b.idle");
      end
      run_frame(3, 8'h13, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      run_frame(0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 8'h77);

      // Reset in the middle of a 0x3C frame
      din = 8'h3C;
      vld[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      for (int k = 0; k < 13; k++) @(negedge clk);
      chk_line(0, 1'b1, "mid.c13");
      rst = 1'b1;
      @(negedge clk);
      chk_line(0, 1'b1, "mid.rst");
      chk_ctl(0, 1'b0, 1'b0, 1'b0, "mid.rst");
      rst = 1'b0;
      @(negedge clk);
      chk_line(0, 1'b1, "mid.rel");
      chk_ctl(0, 1'b0, 1'b1, 1'b0, "mid.rel");
      run_frame(0, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

      // Random words, chaining and ignored mid-frame valids
      for (int n = 0; n < 40; n++) begin
         int i;
         bit ch;
         logic [7:0] w, nw;
         i  = $urandom_range(0, 3);
         ch = 1'($urandom_range(0, 1));
         w  = 8'($urandom);
         nw = 8'($urandom);
         run_frame(i, w, 1'b0, ch, nw, !ch, 8'($urandom));
         if (ch) run_frame(i, nw, 1'b1, 1'b0, 8'h00, 1'b1, 8'($urandom));
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk_line(i, 1'b1, "rnd.idle");
            chk_ctl(i, 1'b0, 1'b1, 1'b0, "rnd.idle");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
